cache_block_memory: RTL and testbench
=====================================

# cache_block_memory

Main-memory responder that sits behind the data cache controller in the memory access stage and services its block refill reads and dirty-block writebacks. The controller raises a read or write request; the memory asserts `busywait`, holds it for a fixed access latency, then commits the write or presents the read block for one cycle. It models a slow backing store so that cache-switching and miss-penalty behaviour can be measured cycle-accurately.

## Interface
- `ADDR_WIDTH`, 28: block address width (byte address bits [31:4]).
- `BLOCK_BITS`, 128: block width (four 32-bit words).
- `DEPTH`, 256: number of blocks stored; power of two.
- `LATENCY`, 5: BUSY cycles per access; legal range 2..15.

- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low.
- `mem_read`  in  1  block read request from cache controller.
- `mem_write`  in  1  block write request from cache controller.
- `mem_address`  in  ADDR_WIDTH  block address.
- `mem_writedata`  in  BLOCK_BITS  block to write.
- `mem_readdata`  out  BLOCK_BITS  block read; valid in DONE cycle.
- `mem_busywait`  out  1  high while a request is pending or in service.

## Operation
- Storage: `DEPTH` x `BLOCK_BITS` array, index = `mem_address[log2(DEPTH)-1:0]`; upper address bits ignored (aliasing). Array is not cleared by reset.
- States: IDLE, BUSY, DONE.
- IDLE: if `mem_read|mem_write` at rising edge -> latch address, writedata, op (write if `mem_write`, else read), counter <= LATENCY-1, go BUSY. Otherwise stay.
- BUSY: counter decrements each edge; at the edge where counter == 0 -> perform access (write: array[index] <= latched data; read: `mem_readdata` <= array[index]), go DONE.
- DONE: one cycle, unconditionally -> IDLE. Requests present in the DONE cycle are ignored; requester must drop them on that edge.
- `mem_busywait` = reset high and ((IDLE and (`mem_read|mem_write`)) or BUSY). Combinational so the requester stalls in the request cycle itself. Low in DONE.
- Both `mem_read` and `mem_write` high: treated as write; `mem_readdata` unchanged.
- Input changes during BUSY are ignored; latched values are used.
- `mem_readdata` holds its value until the next completed read; write accesses do not modify it.

## Timing
- Reset (asynchronous assert): state IDLE, counter 0, `mem_readdata` 0, `mem_busywait` 0 while `reset` low. An in-flight access is aborted and the array is not written.
- Request first high in cycle 0 -> `mem_busywait` high in cycles 0..LATENCY (LATENCY+1 cycles), low in cycle LATENCY+1 (DONE). Read data is valid in DONE and is held afterwards.
- Earliest next acceptance: request high in cycle LATENCY+2 (IDLE) -> busywait high from that cycle. Back-to-back throughput is one access per LATENCY+2 cycles.
- Write is visible to a read accepted in any later IDLE cycle.
- Request dropped in cycle 0 before the edge is not a request; only the value sampled at the edge counts.

## Test plan
- Reset, then write block 0xA5A5A5A5_11111111_22222222_33333333 to address 0x0000010 with LATENCY=5 -> busywait high exactly 6 cycles, low in the 7th; then read 0x0000010 -> same block in DONE cycle, busywait profile identical.
- Back-to-back: read address 0x3 followed by read address 0x4 with requests held until DONE -> second busywait rises in cycle 7, no cycle is lost or merged, each data correct.
- Both `mem_read` and `mem_write` high with data 0xDEADBEEF x4 at address 0x7 -> array[7] written, `mem_readdata` keeps its prior value; subsequent read returns 0xDEADBEEF x4.
- Change `mem_address` and `mem_writedata` in cycle 2 of a write to 0x8 -> only the latched address 0x8 and data are written; the new address is untouched.
- Assert reset in cycle 3 of a write to 0x9 (previously 0) -> busywait 0 immediately, `mem_readdata` 0; after release a read of 0x9 returns 0.
- Alias: write to address 0x0000105 (DEPTH=256) -> read of 0x0000005 returns the same block.

Source files
------------

// File: rtl/cache_block_memory.sv
// cache_block_memory
// Slow main-memory responder behind the data cache controller. Accepts one
// block read or write at a time, stalls the requester for a fixed latency,
// then commits the write or presents the read block for a single DONE cycle.
module cache_block_memory #(
   parameter int ADDR_WIDTH = 28,
   parameter int BLOCK_BITS = 128,
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [BLOCK_BITS-1:0] mem_writedata,
   output logic [BLOCK_BITS-1:0] mem_readdata,
   output logic                  mem_busywait
);

   localparam int          IDX_W    = $clog2(DEPTH);
   // The counter is loaded so that LATENCY edges are spent in BUSY.
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [3:0]              count_q, count_d;
   logic [IDX_W-1:0]        index_q, index_d;
   logic [BLOCK_BITS-1:0]   wdata_q, wdata_d;
   logic                    op_write_q, op_write_d;
   logic [BLOCK_BITS-1:0]   rdata_q, rdata_d;
   logic                    mem_we_s;
   logic                    req_s;
   logic                    unused_addr_s;

   // Backing store; deliberately not cleared by reset.
   logic [BLOCK_BITS-1:0]   mem_array [DEPTH];

   // Upper block-address bits alias onto the stored blocks and are not used.
   assign unused_addr_s = ^mem_address[ADDR_WIDTH-1:IDX_W];

   assign req_s = mem_read | mem_write;

   // Next-state, latching and access decisions for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      index_d    = index_q;
      wdata_d    = wdata_q;
      op_write_d = op_write_q;
      rdata_d    = rdata_q;
      mem_we_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               // A simultaneous read and write is serviced as a write.
               index_d    = mem_address[IDX_W-1:0];
               wdata_d    = mem_writedata;
               op_write_d = mem_write;
               count_d    = CNT_INIT;
               state_d    = ST_BUSY;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (count_q == 4'd0) begin
               state_d = ST_DONE;
               if (op_write_q) begin
                  mem_we_s = 1'b1;
               end else begin
                  rdata_d  = mem_array[index_q];
               end
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         ST_DONE: begin
            // Requests still present here are ignored by design.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            count_d = 4'd0;
         end
      endcase
   end

   // Control and read-data registers; reset aborts any access in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         count_q    <= 4'd0;
         index_q    <= '0;
         wdata_q    <= '0;
         op_write_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         index_q    <= index_d;
         wdata_q    <= wdata_d;
         op_write_q <= op_write_d;
         rdata_q    <= rdata_d;
      end
   end

   // Array write on the final BUSY edge of a write access.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         mem_array[index_q] <= wdata_q;
      end
   end

   assign mem_readdata = rdata_q;

   // Combinational so the requester stalls in the very cycle it asks.
   assign mem_busywait = reset &
                         (((state_q == ST_IDLE) & req_s) | (state_q == ST_BUSY));

endmodule

// File: tb/tb_cache_block_memory.sv
// Directed self-checking bench for cache_block_memory (LATENCY = 5).
module tb_cache_block_memory;

   localparam int LAT = 5;

   logic         clock;
   logic         reset;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   int n_checks;
   int n_pass;

   localparam logic [127:0] BLK_A5 = 128'hA5A5A5A5_11111111_22222222_33333333;
   localparam logic [127:0] BLK_3  = 128'h03030303_30303030_0000AAAA_5555FFFF;
   localparam logic [127:0] BLK_4  = 128'h44444444_0F0F0F0F_F0F0F0F0_12345678;
   localparam logic [127:0] BLK_DB = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [127:0] BLK_8  = 128'h88888888_77777777_66666666_55555555;
   localparam logic [127:0] BLK_X  = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBADBA;
   localparam logic [127:0] BLK_20 = 128'h20202020_CAFEF00D_01234567_89ABCDEF;
   localparam logic [127:0] BLK_FF = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
   localparam logic [127:0] BLK_AL = 128'h10501050_AAAA5555_13579BDF_2468ACE0;

   cache_block_memory #(
      .ADDR_WIDTH (28),
      .BLOCK_BITS (128),
      .DEPTH      (256),
      .LATENCY    (LAT)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_val(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One full access starting just after a rising edge. Checks busywait in
   // every cycle 0..LAT+1 and the read data in the DONE cycle, then returns
   // just after the edge that starts cycle LAT+2 (IDLE).
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [27:0] addr, input logic [127:0] wd,
                         input logic chg, input logic [27:0] chg_addr,
                         input logic [127:0] chg_data,
                         input logic [127:0] exp_rd);
      mem_read      = rd;
      mem_write     = wr;
      mem_address   = addr;
      mem_writedata = wd;
      for (int c = 0; c <= LAT + 1; c++) begin
         if (chg && c == 2) begin
            mem_address   = chg_addr;
            mem_writedata = chg_data;
         end
         #1;
         check_val($sformatf("%s_busy_c%0d", tag, c), {127'd0, mem_busywait},
                   (c <= LAT) ? 128'd1 : 128'd0);
         if (c == LAT + 1) begin
            check_val({tag, "_rdata"}, mem_readdata, exp_rd);
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      reset         = 1'b0;
      mem_read      = 1'b1;
      mem_write     = 1'b0;
      mem_address   = 28'd0;
      mem_writedata = 128'd0;

      // Reset state: busywait masked even with a request pending.
      #12;
      check_val("rst_busy", {127'd0, mem_busywait}, 128'd0);
      check_val("rst_rdata", mem_readdata, 128'd0);
      mem_read = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_val("idle_busy", {127'd0, mem_busywait}, 128'd0);

      // Write then read back the same block.
      access("wr10", 1'b0, 1'b1, 28'h0000010, BLK_A5, 1'b0, 28'd0, 128'd0, 128'd0);
      access("rd10", 1'b1, 1'b0, 28'h0000010, 128'd0, 1'b0, 28'd0, 128'd0, BLK_A5);

      // Back-to-back reads of blocks 3 and 4.
      access("wr3", 1'b0, 1'b1, 28'h3, BLK_3, 1'b0, 28'd0, 128'd0, BLK_A5);
      access("wr4", 1'b0, 1'b1, 28'h4, BLK_4, 1'b0, 28'd0, 128'd0, BLK_A5);
      access("rd3", 1'b1, 1'b0, 28'h3, 128'd0, 1'b0, 28'd0, 128'd0, BLK_3);
      access("rd4", 1'b1, 1'b0, 28'h4, 128'd0, 1'b0, 28'd0, 128'd0, BLK_4);

      // Read and write together: a write that leaves readdata alone.
      access("rw7", 1'b1, 1'b1, 28'h7, BLK_DB, 1'b0, 28'd0, 128'd0, BLK_4);
      access("rd7", 1'b1, 1'b0, 28'h7, 128'd0, 1'b0, 28'd0, 128'd0, BLK_DB);

      // Inputs changed mid-access are ignored.
      access("wr20", 1'b0, 1'b1, 28'h20, BLK_20, 1'b0, 28'd0, 128'd0, BLK_DB);
      access("wr8", 1'b0, 1'b1, 28'h8, BLK_8, 1'b1, 28'h20, BLK_X, BLK_DB);
      access("rd8", 1'b1, 1'b0, 28'h8, 128'd0, 1'b0, 28'd0, 128'd0, BLK_8);
      access("rd20", 1'b1, 1'b0, 28'h20, 128'd0, 1'b0, 28'd0, 128'd0, BLK_20);

      // Reset in cycle 3 of a write to block 9 aborts it.
      access("wr9z", 1'b0, 1'b1, 28'h9, 128'd0, 1'b0, 28'd0, 128'd0, BLK_20);
      mem_write     = 1'b1;
      mem_address   = 28'h9;
      mem_writedata = BLK_FF;
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         #1;
      end
      reset = 1'b0;
      #1;
      check_val("abort_busy", {127'd0, mem_busywait}, 128'd0);
      check_val("abort_rdata", mem_readdata, 128'd0);
      mem_write = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_val("post_rst_busy", {127'd0, mem_busywait}, 128'd0);
      access("rd9", 1'b1, 1'b0, 28'h9, 128'd0, 1'b0, 28'd0, 128'd0, 128'd0);

      // Upper address bits alias onto the same block.
      access("wr105", 1'b0, 1'b1, 28'h0000105, BLK_AL, 1'b0, 28'd0, 128'd0, 128'd0);
      access("rd005", 1'b1, 1'b0, 28'h0000005, 128'd0, 1'b0, 28'd0, 128'd0, BLK_AL);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
